i2c_reg_seq: RTL and testbench

- Transaction sequencer in front of i2c_master. Turns one register-access request into the enable/addr/rw/data_wr sequence that i2c_master expects.
- Write: START, dev+W, reg, data, STOP.
- Read: START, dev+W, reg, repeated START, dev+R, data (NACK), STOP.
- Returns read data and ACK status on a one-cycle response pulse. Sits between the host register bridge and i2c_master.

---
 rtl/i2c_reg_seq.sv | 193 +++++++++++++++++++
 tb/tb_i2c_reg_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_seq.sv
// ============================================================================
//  Module   : i2c_reg_seq
//  Purpose  : Register-access sequencer in front of i2c_master. It turns one
//             write/read request into the enable/addr/rw/data_wr handshake
//             that the master expects. Optional watchdog: I2C_SEQ_WDT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_reg_seq #(
  parameter int STOP_WAIT = 1000
`ifdef I2C_SEQ_WDT_EN
  ,
  parameter int WDT_CYCLES = 65535
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       m_enable,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_wr,
  input  logic       m_busy,
  input  logic       m_ack_error,
  input  logic [7:0] m_data_rd
);

  localparam int                 c_CNT_W    = (STOP_WAIT > 1) ? $clog2(STOP_WAIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(STOP_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_REG   = 3'd2,
    S_DWAIT = 3'd3,
    S_DATA  = 3'd4,
    S_STOPW = 3'd5,
    S_RSP   = 3'd6
  } state_t;

  state_t             r_state;
  logic               r_busy_q;
  logic               r_rw;
  logic [7:0]         r_wdata;
  logic [7:0]         r_rdata;
  logic [c_CNT_W-1:0] r_cnt;

  logic w_rise;
  logic w_fall;
  logic w_accept;
  logic w_err;

  assign w_rise   = m_busy & ~r_busy_q;
  assign w_fall   = ~m_busy & r_busy_q;
  assign w_accept = req_valid & req_ready;

`ifdef I2C_SEQ_WDT_EN
  logic [15:0] r_wdt;
  logic        r_wdt_abort;
  logic        w_wdt_run;
  logic        w_wdt_trip;

  // Counts only while waiting on the master; any busy edge proves progress.
  assign w_wdt_run  = (r_state == S_ADDR) || (r_state == S_REG) ||
                      (r_state == S_DWAIT) || (r_state == S_DATA);
  assign w_wdt_trip = w_wdt_run & ~(w_rise | w_fall) &
                      (r_wdt == 16'(WDT_CYCLES - 1));
  assign w_err      = m_ack_error | r_wdt_abort;
`else
  assign w_err      = m_ack_error;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_busy_q    <= 1'b0;
      r_rw        <= 1'b0;
      r_wdata     <= 8'h00;
      r_rdata     <= 8'h00;
      r_cnt       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_err     <= 1'b0;
      m_enable    <= 1'b0;
      m_addr      <= 7'h00;
      m_rw        <= 1'b0;
      m_data_wr   <= 8'h00;
`ifdef I2C_SEQ_WDT_EN
      r_wdt       <= 16'h0000;
      r_wdt_abort <= 1'b0;
`endif
    end else begin
      r_busy_q  <= m_busy;
      rsp_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rw      <= req_rw;
            r_wdata   <= req_wdata;
            m_addr    <= req_dev;
            m_rw      <= 1'b0;
            m_data_wr <= req_reg;
            m_enable  <= 1'b1;
            req_ready <= 1'b0;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_rise) begin
            r_state <= S_REG;
          end
        end
        S_REG: begin
          // A read flips rw so the master issues a repeated START with dev+R.
          if (w_fall) begin
            if (r_rw) begin
              m_rw <= 1'b1;
            end else begin
              m_data_wr <= r_wdata;
            end
            r_state <= S_DWAIT;
          end
        end
        S_DWAIT: begin
          if (w_rise) begin
            m_enable <= 1'b0;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_rdata <= r_rw ? m_data_rd : 8'h00;
            r_cnt   <= c_CNT_LOAD;
            r_state <= S_STOPW;
          end
        end
        S_STOPW: begin
          if (r_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= r_rdata;
            rsp_err   <= w_err;
            r_state   <= S_RSP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RSP: begin
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

`ifdef I2C_SEQ_WDT_EN
      if (w_accept) begin
        r_wdt       <= 16'h0000;
        r_wdt_abort <= 1'b0;
      end else if (w_wdt_run) begin
        if (w_rise | w_fall) begin
          r_wdt <= 16'h0000;
        end else begin
          r_wdt <= r_wdt + 16'h0001;
        end
      end

      // Abort overrides the normal flow and still passes through STOPW.
      if (w_wdt_trip) begin
        m_enable    <= 1'b0;
        r_wdt_abort <= 1'b1;
        r_rdata     <= 8'h00;
        r_cnt       <= c_CNT_LOAD;
        r_state     <= S_STOPW;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
// ============================================================================
//  Module   : tb_i2c_reg_seq
//  Purpose  : Self-checking bench for i2c_reg_seq with a byte-level
//             i2c_master + slave model. Watchdog cases need I2C_SEQ_WDT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_reg_seq;

  localparam int STOP_WAIT = 8;
  localparam int WDT       = 200;
  localparam int BT        = 20;
  localparam int GAP       = 4;
  localparam int LOG_S     = 256;
  localparam int LOG_SR    = 257;
  localparam int LOG_P     = 258;
  localparam int LOG_NACK  = 259;
  localparam logic [6:0] SLV = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       m_enable;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data_wr;
  logic       m_busy;
  logic       m_ack_error;
  logic [7:0] m_data_rd;

  always #5 clk = ~clk;

  i2c_reg_seq #(
    .STOP_WAIT (STOP_WAIT)
`ifdef I2C_SEQ_WDT_EN
    ,
    .WDT_CYCLES(WDT)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_dev    (req_dev),
    .req_reg    (req_reg),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .m_enable   (m_enable),
    .m_addr     (m_addr),
    .m_rw       (m_rw),
    .m_data_wr  (m_data_wr),
    .m_busy     (m_busy),
    .m_ack_error(m_ack_error),
    .m_data_rd  (m_data_rd)
  );

  // Byte-level master + single slave at 0x50; every bus event goes to bus_log.
  typedef enum logic [1:0] {M_IDLE, M_BYTE, M_ACK} mst_t;
  mst_t       ms;
  int         mcnt;
  logic [7:0] cur_ar;
  logic [7:0] tx;
  logic [7:0] rd_v;
  logic       first_dat;
  logic [7:0] ptr;
  logic       stuck = 1'b0;
  logic [7:0] mem [256];
  int         bus_log[$];
  int         exp_log[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms          <= M_IDLE;
      mcnt        <= 0;
      m_busy      <= 1'b0;
      m_ack_error <= 1'b0;
      m_data_rd   <= 8'h00;
      cur_ar      <= 8'h00;
      tx          <= 8'h00;
      first_dat   <= 1'b0;
      ptr         <= 8'h00;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h34]  <= 8'h5C;
    end else begin
      case (ms)
        M_IDLE: begin
          if (m_enable && !stuck) begin
            bus_log.push_back(LOG_S);
            bus_log.push_back(int'({m_addr, m_rw}));
            cur_ar      <= {m_addr, m_rw};
            m_ack_error <= (m_addr != SLV);
            tx          <= m_data_wr;
            first_dat   <= 1'b1;
            m_busy      <= 1'b1;
            mcnt        <= BT;
            ms          <= M_BYTE;
          end
        end
        M_BYTE: begin
          if (mcnt > 0) begin
            mcnt <= mcnt - 1;
          end else begin
            if (!cur_ar[0]) begin
              bus_log.push_back(int'(tx));
              if (cur_ar[7:1] == SLV) begin
                if (first_dat) ptr <= tx;
                else mem[ptr] <= tx;
              end
            end else begin
              rd_v = (cur_ar[7:1] == SLV) ? mem[ptr] : 8'hFF;
              m_data_rd <= rd_v;
              bus_log.push_back(int'(rd_v));
            end
            first_dat <= 1'b0;
            m_busy    <= 1'b0;
            mcnt      <= GAP;
            ms        <= M_ACK;
          end
        end
        default: begin
          if (mcnt > 0) begin
            mcnt <= mcnt - 1;
          end else if (m_enable) begin
            if ({m_addr, m_rw} != cur_ar) begin
              bus_log.push_back(LOG_SR);
              bus_log.push_back(int'({m_addr, m_rw}));
              cur_ar <= {m_addr, m_rw};
              if (m_addr != SLV) m_ack_error <= 1'b1;
            end
            tx     <= m_data_wr;
            m_busy <= 1'b1;
            mcnt   <= BT;
            ms     <= M_BYTE;
          end else begin
            if (cur_ar[0]) bus_log.push_back(LOG_NACK);
            bus_log.push_back(LOG_P);
            ms <= M_IDLE;
          end
        end
      endcase
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_bus(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [7:0] wd, input logic [7:0] rd);
    exp_log.delete();
    exp_log.push_back(LOG_S);
    exp_log.push_back(int'({dev, 1'b0}));
    exp_log.push_back(int'(ra));
    if (!rw) begin
      exp_log.push_back(int'(wd));
    end else begin
      exp_log.push_back(LOG_SR);
      exp_log.push_back(int'({dev, 1'b1}));
      exp_log.push_back(int'(rd));
      exp_log.push_back(LOG_NACK);
    end
    exp_log.push_back(LOG_P);
  endtask

  task automatic check_bus(input string name);
    int bad;
    bad = -1;
    checks++;
    if (bus_log.size() != exp_log.size()) begin
      failures++;
      $display("FAIL %s: bus has %0d events expected %0d", name, bus_log.size(), exp_log.size());
    end else begin
      for (int k = 0; k < exp_log.size(); k++)
        if (bus_log[k] != exp_log[k] && bad < 0) bad = k;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s: bus event %0d got 0x%0h expected 0x%0h", name, bad, bus_log[bad], exp_log[bad]);
      end
    end
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  // Call at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic run_req(input vec_t v, output logic [7:0] rd, output logic er, output logic got);
    int n;
    bus_log.delete();
    req_rw    = v.rw;
    req_dev   = v.dev;
    req_reg   = v.ra;
    req_wdata = v.wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    rd  = 8'h00;
    er  = 1'b0;
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    if (rsp_valid) begin
      got = 1'b1;
      rd  = rsp_rdata;
      er  = rsp_err;
    end
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    logic [7:0] rd;
    logic       er;
    logic       got;
    run_req(v, rd, er, got);
    check({tag, "_rsp_seen"}, got, 1);
    check({tag, "_rdata"}, rd, v.exp_rd);
    check({tag, "_err"}, er, v.exp_err);
    expect_bus(v.rw, v.dev, v.ra, v.wd, v.exp_rd);
    check_bus({tag, "_bus"});
    @(negedge clk);
    check({tag, "_single_pulse"}, rsp_valid, 0);
    check({tag, "_ready_back"}, req_ready, 1);
    check({tag, "_rdata_hold"}, rsp_rdata, v.exp_rd);
    check({tag, "_err_hold"}, rsp_err, v.exp_err);
  endtask

  vec_t vecs[7];

  initial begin
    logic [7:0] rd;
    logic       er;
    logic       early;
    int         n;

    vecs[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, 1'b0};
    vecs[2] = '{1'b0, 7'h21, 8'h01, 8'h77, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 7'h50, 8'h12, 8'h00, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 7'h21, 8'h00, 8'h00, 8'hFF, 1'b1};
    vecs[5] = '{1'b0, 7'h50, 8'hFF, 8'h81, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 7'h50, 8'hFF, 8'h00, 8'h81, 1'b0};

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_m_enable", m_enable, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_rw", m_rw, 0);
    check("rst_m_data_wr", m_data_wr, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_and_check($sformatf("v%0d", i), vecs[i]);

    // Back-to-back with req_valid held; fields change after the first accept.
    bus_log.delete();
    req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h20; req_wdata = 8'h3C;
    req_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready_drop", req_ready, 0);
    req_rw = 1'b1; req_wdata = 8'hEE;
    early = 1'b0;
    n = 0;
    while (!rsp_valid && n < 3000) begin
      if (req_ready) early = 1'b1;
      @(negedge clk);
      n++;
    end
    check("b2b_first_rsp", rsp_valid, 1);
    check("b2b_no_early_accept", early, 0);
    check("b2b_first_err", rsp_err, 0);
    check("b2b_first_rdata", rsp_rdata, 8'h00);
    expect_bus(1'b0, 7'h50, 8'h20, 8'h3C, 8'h00);
    check_bus("b2b_first_bus");
    bus_log.delete();
    @(negedge clk);
    check("b2b_ready_after_rsp", req_ready, 1);
    @(negedge clk);
    check("b2b_second_accept", req_ready, 0);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    check("b2b_second_rsp", rsp_valid, 1);
    check("b2b_second_rdata", rsp_rdata, 8'h3C);
    check("b2b_second_err", rsp_err, 0);
    expect_bus(1'b1, 7'h50, 8'h20, 8'h00, 8'h3C);
    check_bus("b2b_second_bus");
    @(negedge clk);

    // Asynchronous reset mid-transaction: early (enable high) and in DATA.
    for (int ph = 0; ph < 2; ph++) begin
      req_rw = 1'b1; req_dev = 7'h50; req_reg = 8'h34; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      if (ph == 0) begin
        repeat (3) @(negedge clk);
        check("rst0_pre_enable", m_enable, 1);
      end else begin
        n = 0;
        while (m_enable && n < 500) begin @(negedge clk); n++; end
        check("rst1_reached_data", m_enable, 0);
        repeat (3) @(negedge clk);
        check("rst1_pre_ready", req_ready, 0);
      end
      #2 rst = 1'b0;
      #1;
      check($sformatf("rst%0d_m_enable", ph), m_enable, 0);
      check($sformatf("rst%0d_req_ready", ph), req_ready, 1);
      check($sformatf("rst%0d_rsp_valid", ph), rsp_valid, 0);
      check($sformatf("rst%0d_m_addr", ph), m_addr, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    end
    run_and_check("post_rst_wr", '{1'b0, 7'h50, 8'h56, 8'hC3, 8'h00, 1'b0});
    run_and_check("post_rst_rd", '{1'b1, 7'h50, 8'h56, 8'h00, 8'hC3, 1'b0});

`ifdef I2C_SEQ_WDT_EN
    stuck = 1'b1;
    req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h10; req_wdata = 8'h11;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (199) @(negedge clk);
    check("wdt_enable_before", m_enable, 1);
    @(negedge clk);
    check("wdt_enable_dropped", m_enable, 0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("wdt_rsp_seen", rsp_valid, 1);
    check("wdt_stopwait_cycles", n, STOP_WAIT);
    check("wdt_err", rsp_err, 1);
    check("wdt_rdata", rsp_rdata, 0);
    stuck = 1'b0;
    @(negedge clk);
    check("wdt_ready_back", req_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
